// File: rtl/alu4_pkg.sv
// Shared types for the ALU4 operand-issue stage: ctl codes, FSM states and the queued op record.
package alu4_pkg;

  localparam logic [2:0] CTL_ADD  = 3'b000;
  localparam logic [2:0] CTL_AND  = 3'b001;
  localparam logic [2:0] CTL_OR   = 3'b010;
  localparam logic [2:0] CTL_XNOR = 3'b011;
  localparam logic [2:0] CTL_SUB  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] ctl;
    logic       use_acc;
  } op_t;

endpackage

// File: rtl/alu4_op_fifo.sv
// Op queue, DEPTH entries (power of two); head visible combinationally, 1-cycle push-to-head latency.
// Push is refused while full, even when a pop happens in the same cycle (no pass-through).
module alu4_op_fifo
  import alu4_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  op_t  push_dat_i,
  input  logic pop_i,
  output op_t  head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  op_t           mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/alu4_op_stage.sv
// Issue stage for ALU4: accept->valid 2 edges, one result per 2 cycles; result held while !out_ready.
// ALU4_OP_ACC_EN builds the accumulator that can stand in for operand a.
module alu4_op_stage
  import alu4_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic [2:0] in_ctl,
  input  logic       in_use_acc,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_ctl,
  input  logic [3:0] alu_z,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_z,
  output logic       out_zero,
  output logic [2:0] out_ctl,
  output logic [3:0] acc
);

  state_e     state_q, state_d;
  op_t        push_dat, head;
  logic       full, empty, pop;
  logic [3:0] op_a;
  logic [3:0] alu_a_q, alu_b_q, out_z_q;
  logic [2:0] alu_ctl_q, out_ctl_q;
  logic       out_zero_q;

  assign push_dat = '{a: in_a, b: in_b, ctl: in_ctl, use_acc: in_use_acc};

  alu4_op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (in_valid),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty)
  );

`ifdef ALU4_OP_ACC_EN
  logic [3:0] acc_q;

  // acc is written at the capture edge, so a pop from HOLD already sees the chained value.
  assign op_a = head.use_acc ? acc_q : head.a;
  assign acc  = acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  acc_q <= '0;
    else if (state_q == ST_EXEC) acc_q <= alu_z;
  end
`else
  logic unused_use_acc;

  assign unused_use_acc = head.use_acc;
  assign op_a           = head.a;
  assign acc            = 4'h0;
`endif

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_HOLD;
      ST_HOLD: if (out_ready) begin
        pop     = !empty;
        state_d = empty ? ST_IDLE : ST_EXEC;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The operand register doubles as the ALU drive, so alu_* only move on a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctl_q  <= CTL_ADD;
      out_z_q    <= '0;
      out_zero_q <= 1'b0;
      out_ctl_q  <= CTL_ADD;
    end else begin
      state_q <= state_d;
      if (pop) begin
        alu_a_q   <= op_a;
        alu_b_q   <= head.b;
        alu_ctl_q <= head.ctl;
      end
      if (state_q == ST_EXEC) begin
        out_z_q    <= alu_z;
        out_zero_q <= (alu_z == 4'h0);
        out_ctl_q  <= alu_ctl_q;
      end
    end
  end

  assign in_ready  = !full;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctl   = alu_ctl_q;
  assign out_valid = (state_q == ST_HOLD);
  assign out_z     = out_z_q;
  assign out_zero  = out_zero_q;
  assign out_ctl   = out_ctl_q;

endmodule

// File: tb/tb_alu4_op_stage.sv
// Directed bench for alu4_op_stage with a behavioural ALU4 on the alu_* loop.
module tb_alu4_op_stage;
  import alu4_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_use_acc;
  logic [3:0] in_a, in_b;
  logic [2:0] in_ctl;
  logic [3:0] alu_a, alu_b, alu_z;
  logic [2:0] alu_ctl;
  logic       out_valid, out_ready, out_zero;
  logic [3:0] out_z, acc;
  logic [2:0] out_ctl;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu4_op_stage #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_ctl     (in_ctl),
    .in_use_acc (in_use_acc),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctl    (alu_ctl),
    .alu_z      (alu_z),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_z      (out_z),
    .out_zero   (out_zero),
    .out_ctl    (out_ctl),
    .acc        (acc)
  );

  always_comb begin
    alu_z = 4'h0;
    case (alu_ctl)
      CTL_ADD:  alu_z = alu_a + alu_b;
      CTL_AND:  alu_z = alu_a & alu_b;
      CTL_OR:   alu_z = alu_a | alu_b;
      CTL_XNOR: alu_z = ~(alu_a ^ alu_b);
      CTL_SUB:  alu_z = alu_a - alu_b;
      default:  alu_z = 4'h0;
    endcase
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] ctl,
                      input logic use_acc);
    in_valid   = 1'b1;
    in_a       = a;
    in_b       = b;
    in_ctl     = ctl;
    in_use_acc = use_acc;
    tick();
    in_valid   = 1'b0;
  endtask

  // Waits for a result, checks it, then lets it be consumed (out_ready assumed high).
  task automatic wait_result(input string tag, input logic [3:0] exp_z, input logic [2:0] exp_ctl);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check({tag, "_vld"}, out_valid, 1'b1);
    check({tag, "_z"}, out_z, exp_z);
    check({tag, "_zero"}, out_zero, exp_z == 4'h0);
    check({tag, "_ctl"}, out_ctl, exp_ctl);
    tick();
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] ctl, input logic use_acc, input logic [3:0] exp_z);
    push(a, b, ctl, use_acc);
    wait_result(tag, exp_z, ctl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_ctl = '0; in_use_acc = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_vld", out_valid, 1'b0);
    check("rst_rdy", in_ready, 1'b1);
    check("rst_z", out_z, 4'h0);
    check("rst_acc", acc, 4'h0);
    check("rst_alu_a", alu_a, 4'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single add with edge-by-edge latency
    in_valid = 1'b1; in_a = 4'd3; in_b = 4'd4; in_ctl = CTL_ADD; in_use_acc = 1'b0;
    tick();
    in_valid = 1'b0;
    check("add_e0_vld", out_valid, 1'b0);
    tick();
    check("add_e1_vld", out_valid, 1'b0);
    check("add_e1_alu_a", alu_a, 4'd3);
    check("add_e1_alu_b", alu_b, 4'd4);
    tick();
    check("add_e2_vld", out_valid, 1'b1);
    check("add_e2_z", out_z, 4'b0111);
    check("add_e2_zero", out_zero, 1'b0);
    check("add_e2_ctl", out_ctl, CTL_ADD);
    tick();
    check("add_e3_vld", out_valid, 1'b0);

    run_op("sub_wrap", 4'd2, 4'd5, CTL_SUB, 1'b0, 4'b1101);
    run_op("sub_zero", 4'd6, 4'd6, CTL_SUB, 1'b0, 4'b0000);
    run_op("and", 4'b1010, 4'b0110, CTL_AND, 1'b0, 4'b0010);
    run_op("or", 4'b1010, 4'b0110, CTL_OR, 1'b0, 4'b1110);
    run_op("xnor", 4'b1010, 4'b0110, CTL_XNOR, 1'b0, 4'b0011);

    // Accumulator chain; queued a=4 is what the non-accumulator build uses
    run_op("chain1", 4'd5, 4'd3, CTL_ADD, 1'b0, 4'b1000);
`ifdef ALU4_OP_ACC_EN
    check("chain1_acc", acc, 4'b1000);
    run_op("chain2", 4'd4, 4'd9, CTL_ADD, 1'b1, 4'b0001);
    check("chain2_acc", acc, 4'b0001);
    run_op("chain3", 4'd4, 4'd1, CTL_SUB, 1'b1, 4'b0000);
    check("chain3_acc", acc, 4'b0000);
`else
    check("chain1_acc", acc, 4'h0);
    run_op("chain2", 4'd4, 4'd9, CTL_ADD, 1'b1, 4'b1101);
    run_op("chain3", 4'd4, 4'd1, CTL_SUB, 1'b1, 4'b0011);
    check("chain3_acc", acc, 4'h0);
`endif

    // Backpressure: three ops behind a held result
    out_ready = 1'b0;
    push(4'd1, 4'd1, CTL_ADD, 1'b0);
    push(4'd2, 4'd2, CTL_ADD, 1'b0);
    check("bp_rdy_before_full", in_ready, 1'b1);
    push(4'd3, 4'd3, CTL_ADD, 1'b0);
    check("bp_full_rdy", in_ready, 1'b0);
    check("bp_hold_vld", out_valid, 1'b1);
    check("bp_hold_z", out_z, 4'd2);
    in_valid = 1'b1; in_a = 4'hf; in_b = 4'hf; in_ctl = CTL_ADD;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_stable_z", out_z, 4'd2);
      check("bp_stable_rdy", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_drain1_vld", out_valid, 1'b0);
    check("bp_drain1_rdy", in_ready, 1'b1);
    tick();
    check("bp_drain2_vld", out_valid, 1'b1);
    check("bp_drain2_z", out_z, 4'd4);
    tick();
    check("bp_drain3_vld", out_valid, 1'b0);
    tick();
    check("bp_drain4_vld", out_valid, 1'b1);
    check("bp_drain4_z", out_z, 4'd6);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_no_extra", out_valid, 1'b0);
    end

    // Reset during EXEC with another op queued
    push(4'd5, 4'd6, CTL_ADD, 1'b0);
    push(4'd7, 4'd1, CTL_SUB, 1'b0);
    check("mid_exec_alu_a", alu_a, 4'd5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", out_valid, 1'b0);
    check("mid_rst_z", out_z, 4'h0);
    check("mid_rst_zero", out_zero, 1'b0);
    check("mid_rst_ctl", out_ctl, 3'b000);
    check("mid_rst_acc", acc, 4'h0);
    check("mid_rst_alu_a", alu_a, 4'h0);
    check("mid_rst_alu_b", alu_b, 4'h0);
    check("mid_rst_alu_ctl", alu_ctl, 3'b000);
    check("mid_rst_rdy", in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_no_stale", out_valid, 1'b0);
    end
    run_op("post_rst_add", 4'd1, 4'd1, CTL_ADD, 1'b0, 4'b0010);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
